acc_stack_unit: RTL and testbench
=================================

# acc_stack_unit

Parametrised accumulator register with integrated ALU operations, status flags and a save/restore LIFO. It is the next-generation datapath accumulator for the CPU and replaces the plain 8-bit load-only accumulator. The control unit drives one opcode per cycle; the unit holds the working value, updates the flags, and can push or pop the accumulator to a small internal stack for subroutine and interrupt context saves.

## Interface
- WIDTH, 8: data path width in bits (>= 2).
- DEPTH, 4: number of LIFO entries (>= 1).

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  qualifies op; when low, all state holds.
- op  input  3  operation code (acc_pkg::acc_op_t).
- data_in  input  WIDTH  operand for LOAD/ADD/SUB.
- data_out  output  WIDTH  current accumulator value, driven directly from the register.
- carry  output  1  carry/borrow/shifted-out bit.
- zero  output  1  accumulator == 0.
- neg  output  1  accumulator MSB.
- stack_full  output  1  DEPTH entries stored.
- stack_empty  output  1  no entries stored.
- stack_err  output  1  sticky: push when full or pop when empty occurred.

## Operation
- Opcodes: NOP=0, LOAD=1, ADD=2, SUB=3, SHL=4, SHR=5, PUSH=6, POP=7.
- LOAD: acc <= data_in; zero/neg updated; carry unchanged.
- ADD: {carry, acc} <= acc + data_in (WIDTH+1-bit sum); zero/neg from result.
- SUB: acc <= acc - data_in modulo 2^WIDTH; carry <= 1 when data_in > acc (unsigned borrow); zero/neg from result.
- SHL: acc <= acc << 1, LSB 0; carry <= old MSB. SHR: logical, MSB 0; carry <= old LSB. zero/neg from result.
- PUSH: stack[sp] <= acc, sp <= sp+1; acc and flags unchanged. When full: no write, sp holds, stack_err <= 1.
- POP: sp <= sp-1, acc <= stack[sp-1]; zero/neg updated; carry unchanged. When empty: acc, flags and sp hold, stack_err <= 1.
- NOP or enable=0: no state change.
- stack_err clears only on reset.
- sp is $clog2(DEPTH+1) bits wide; stack_full = (sp == DEPTH); stack_empty = (sp == 0). No wrap-around: sp never exceeds DEPTH and never goes below 0.
- Stack contents are not reset; only sp is cleared, so stale entries are unreachable.

## Timing
- Single-cycle: an op sampled on edge N is visible on data_out and flags immediately after edge N. A back-to-back op on edge N+1 uses the updated value.
- Reset dominates enable and op. After a reset edge: data_out=0, carry=0, zero=1, neg=0, sp=0 (stack_empty=1, stack_full=0), stack_err=0.
- A reset asserted in the same cycle as PUSH or POP cancels the operation. No partial stack write.
- Outputs are pure register outputs, with no combinational path from inputs.

## Structure
- Package acc_pkg: acc_op_t enum (3-bit) with the opcode values above.
- Sub-module acc_lifo(WIDTH, DEPTH): storage array, sp, full/empty, push/pop strobes and read data. Error detection and the accumulator/flag logic stay in the top level.

## Test plan
- Reset, then idle -> data_out=0x00, zero=1, carry=0, stack_empty=1, stack_err=0.
- LOAD 0x0F, ADD 0xF1 -> data_out=0x00, carry=1, zero=1, neg=0.
- LOAD 0x05, SUB 0x07 -> data_out=0xFE, carry=1, neg=1, zero=0. Then SHR -> 0x7F, carry=0, neg=0.
- LOAD 0x11/PUSH, LOAD 0x22/PUSH, LOAD 0x33/PUSH, LOAD 0x44/PUSH -> stack_full=1. A fifth PUSH -> stack_err=1 and sp unchanged. Four POPs return 0x44, 0x33, 0x22, 0x11, then stack_empty=1. A fifth POP leaves data_out=0x11.
- enable=0 with op=ADD and data_in=0xFF -> no change to any output for 5 cycles.
- Reset asserted during PUSH with the stack holding 2 entries -> next cycle sp=0, data_out=0, stack_err=0. A following POP sets stack_err=1.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared opcode definitions for the accumulator/stack datapath.
package acc_pkg;

  // One opcode per cycle from the control unit.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_PUSH = 3'd6,
    OP_POP  = 3'd7
  } acc_op_t;

endpackage

// File: rtl/acc_lifo.sv
// Small save/restore LIFO for accumulator context.
// The caller only raises push_i when not full and pop_i when not empty.
// Storage is deliberately left unreset; clearing sp makes old entries unreachable.
module acc_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int SpW  = $clog2(DEPTH + 1);
  localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SpW-1:0]   sp_q;
  logic [SpW-1:0]   sp_d;
  logic [SpW-1:0]   topIdx;
  logic [IdxW-1:0]  wrIdx;
  logic [IdxW-1:0]  rdIdx;

  assign topIdx  = sp_q - SpW'(1);
  assign wrIdx   = sp_q[IdxW-1:0];
  assign rdIdx   = topIdx[IdxW-1:0];
  assign full_o  = (sp_q == SpW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rdIdx];

  // Stack pointer next state: a push and a pop never arrive together.
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  // Stack pointer register; reset empties the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry write; a coincident reset cancels the push so nothing is half-saved.
  always_ff @(posedge clk) begin
    if (!reset && push_i && !full_o) begin
      mem_q[wrIdx] <= wdata_i;
    end
  end

endmodule

// File: rtl/acc_stack_unit.sv
// Accumulator with ALU ops, status flags and a save/restore LIFO.
// Every output comes straight from a register or from LIFO pointer state.
module acc_stack_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  acc_op_t          op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             stackErr_q, stackErr_d;

  logic             pushStb;
  logic             popStb;
  logic [WIDTH-1:0] lifoRdata;
  logic             lifoFull;
  logic             lifoEmpty;
  logic [WIDTH:0]   sumWide;
  logic [WIDTH-1:0] diff;

  assign sumWide = {1'b0, acc_q} + {1'b0, data_in};
  assign diff    = acc_q - data_in;

  acc_lifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_lifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (pushStb),
    .pop_i  (popStb),
    .wdata_i(acc_q),
    .rdata_o(lifoRdata),
    .full_o (lifoFull),
    .empty_o(lifoEmpty)
  );

  // Decode the opcode into next accumulator, flags and stack strobes.
  always_comb begin
    acc_d      = acc_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    stackErr_d = stackErr_q;
    pushStb    = 1'b0;
    popStb     = 1'b0;
    if (enable && !reset) begin
      case (op)
        OP_LOAD: acc_d = data_in;
        OP_ADD: begin
          acc_d   = sumWide[WIDTH-1:0];
          carry_d = sumWide[WIDTH];
        end
        OP_SUB: begin
          acc_d   = diff;
          carry_d = (data_in > acc_q);
        end
        OP_SHL: begin
          acc_d   = {acc_q[WIDTH-2:0], 1'b0};
          carry_d = acc_q[WIDTH-1];
        end
        OP_SHR: begin
          acc_d   = {1'b0, acc_q[WIDTH-1:1]};
          carry_d = acc_q[0];
        end
        OP_PUSH: begin
          if (lifoFull) begin
            stackErr_d = 1'b1;
          end else begin
            pushStb = 1'b1;
          end
        end
        OP_POP: begin
          if (lifoEmpty) begin
            stackErr_d = 1'b1;
          end else begin
            popStb = 1'b1;
            acc_d  = lifoRdata;
          end
        end
        default: ;
      endcase
      if (op != OP_NOP && op != OP_PUSH) begin
        zero_d = (acc_d == '0);
        neg_d  = acc_d[WIDTH-1];
      end
    end
  end

  // Accumulator and flag registers; reset leaves a zero accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
      stackErr_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      stackErr_q <= stackErr_d;
    end
  end

  assign data_out    = acc_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign neg         = neg_q;
  assign stack_full  = lifoFull;
  assign stack_empty = lifoEmpty;
  assign stack_err   = stackErr_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
// Directed test for acc_stack_unit with hand-computed expectations.
module tb_acc_stack_unit;
  import acc_pkg::*;

  logic       clk;
  logic       reset;
  logic       enable;
  acc_op_t    op;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       carry;
  logic       zero;
  logic       neg;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int compareCount  = 0;
  int mismatchCount = 0;

  acc_stack_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .op         (op),
    .data_in    (data_in),
    .data_out   (data_out),
    .carry      (carry),
    .zero       (zero),
    .neg        (neg),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 unit after the rising edge.
  task automatic applyStimulus(input logic en, input acc_op_t o, input logic [7:0] d);
    enable  = en;
    op      = o;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Check all value flags at once.
  task automatic checkFlags(input string tag, input logic [7:0] expData,
                            input logic expCarry, input logic expZero, input logic expNeg);
    checkOutput({tag, ".data"},  32'(data_out), 32'(expData));
    checkOutput({tag, ".carry"}, 32'(carry),    32'(expCarry));
    checkOutput({tag, ".zero"},  32'(zero),     32'(expZero));
    checkOutput({tag, ".neg"},   32'(neg),      32'(expNeg));
  endtask

  logic [7:0] pushVals [4];

  initial begin
    pushVals[0] = 8'h11;
    pushVals[1] = 8'h22;
    pushVals[2] = 8'h33;
    pushVals[3] = 8'h44;

    reset   = 1'b1;
    enable  = 1'b0;
    op      = OP_NOP;
    data_in = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then one idle cycle.
    checkFlags("rst", 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("rst.empty", 32'(stack_empty), 32'd1);
    checkOutput("rst.full",  32'(stack_full),  32'd0);
    checkOutput("rst.err",   32'(stack_err),   32'd0);
    applyStimulus(1'b1, OP_NOP, 8'hA5);
    checkFlags("idle", 8'h00, 1'b0, 1'b1, 1'b0);

    // Add with wrap to zero.
    applyStimulus(1'b1, OP_LOAD, 8'h0F);
    checkFlags("load0f", 8'h0F, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ADD, 8'hF1);
    checkFlags("addwrap", 8'h00, 1'b1, 1'b1, 1'b0);

    // Add without overflow clears carry; LOAD keeps carry.
    applyStimulus(1'b1, OP_LOAD, 8'h10);
    checkFlags("loadkeepc", 8'h10, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ADD, 8'h20);
    checkFlags("addnc", 8'h30, 1'b0, 1'b0, 1'b0);

    // Subtract with borrow, then logical shift right.
    applyStimulus(1'b1, OP_LOAD, 8'h05);
    applyStimulus(1'b1, OP_SUB, 8'h07);
    checkFlags("subborrow", 8'hFE, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_SHR, 8'h00);
    checkFlags("shr", 8'h7F, 1'b0, 1'b0, 1'b0);

    // Subtract to zero without borrow.
    applyStimulus(1'b1, OP_SUB, 8'h7F);
    checkFlags("subzero", 8'h00, 1'b0, 1'b1, 1'b0);

    // Shift left moves the MSB into carry.
    applyStimulus(1'b1, OP_LOAD, 8'h81);
    applyStimulus(1'b1, OP_SHL, 8'h00);
    checkFlags("shl", 8'h02, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SHR, 8'h00);
    checkFlags("shr2", 8'h01, 1'b0, 1'b0, 1'b0);

    // Fill the stack.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, OP_LOAD, pushVals[i]);
      applyStimulus(1'b1, OP_PUSH, 8'h00);
      checkOutput($sformatf("push%0d.data", i), 32'(data_out), 32'(pushVals[i]));
      checkOutput($sformatf("push%0d.full", i), 32'(stack_full), (i == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("fill.empty", 32'(stack_empty), 32'd0);
    checkOutput("fill.err",   32'(stack_err),   32'd0);

    // Overflowing push flags an error and changes nothing else.
    applyStimulus(1'b1, OP_LOAD, 8'h99);
    applyStimulus(1'b1, OP_PUSH, 8'h00);
    checkOutput("ovf.err",  32'(stack_err),  32'd1);
    checkOutput("ovf.full", 32'(stack_full), 32'd1);
    checkOutput("ovf.data", 32'(data_out),   32'h99);

    // Drain in reverse order.
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b1, OP_POP, 8'h00);
      checkOutput($sformatf("pop%0d.data", i), 32'(data_out), 32'(pushVals[i]));
      checkOutput($sformatf("pop%0d.full", i), 32'(stack_full), 32'd0);
      checkOutput($sformatf("pop%0d.empty", i), 32'(stack_empty), (i == 0) ? 32'd1 : 32'd0);
    end

    // Underflowing pop leaves the accumulator alone.
    applyStimulus(1'b1, OP_POP, 8'h00);
    checkFlags("unf", 8'h11, 1'b0, 1'b0, 1'b0);
    checkOutput("unf.empty", 32'(stack_empty), 32'd1);
    checkOutput("unf.err",   32'(stack_err),   32'd1);

    // Pop updates neg/zero from the restored value.
    applyStimulus(1'b1, OP_LOAD, 8'h80);
    applyStimulus(1'b1, OP_PUSH, 8'h00);
    applyStimulus(1'b1, OP_LOAD, 8'h00);
    checkFlags("ld00", 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_POP, 8'h00);
    checkFlags("popneg", 8'h80, 1'b0, 1'b0, 1'b1);

    // Disabled cycles hold every output.
    applyStimulus(1'b1, OP_LOAD, 8'h55);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, OP_ADD, 8'hFF);
      checkFlags($sformatf("hold%0d", i), 8'h55, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("hold%0d.empty", i), 32'(stack_empty), 32'd1);
      checkOutput($sformatf("hold%0d.err", i),   32'(stack_err),   32'd1);
    end

    // Reset cancels a push with two entries stored.
    reset = 1'b1;
    applyStimulus(1'b0, OP_NOP, 8'h00);
    reset = 1'b0;
    checkOutput("rst2.err", 32'(stack_err), 32'd0);
    applyStimulus(1'b1, OP_LOAD, 8'hAA);
    applyStimulus(1'b1, OP_PUSH, 8'h00);
    applyStimulus(1'b1, OP_LOAD, 8'hBB);
    applyStimulus(1'b1, OP_PUSH, 8'h00);
    checkOutput("two.empty", 32'(stack_empty), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b1, OP_PUSH, 8'h00);
    reset = 1'b0;
    checkFlags("rstpush", 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("rstpush.empty", 32'(stack_empty), 32'd1);
    checkOutput("rstpush.full",  32'(stack_full),  32'd0);
    checkOutput("rstpush.err",   32'(stack_err),   32'd0);
    applyStimulus(1'b1, OP_POP, 8'h00);
    checkOutput("postrst.err",   32'(stack_err),   32'd1);
    checkOutput("postrst.data",  32'(data_out),    32'h00);
    checkOutput("postrst.empty", 32'(stack_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
